seq_signed_divider: RTL and testbench

Sequential radix-2 restoring divider. It is the inverse-operation companion to the team's sequential Booth multiplier.
- Divides a signed Width_inputs-bit dividend by a signed Width_inputs-bit divisor.
- Produces a quotient truncated toward zero and a remainder that carries the sign of the dividend.
- Internally it has a small FSM controller plus a shift/subtract datapath.
- Its operand-load interface matches the multiplier, so both blocks sit side by side in the arithmetic unit.

---
 rtl/seq_signed_divider.sv | 120 ++++++++++++
 tb/tb_seq_signed_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: radix-2 restoring signed divider, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module seq_signed_divider #(
  parameter int Width_inputs = 16,
  parameter int Width_count  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [Width_inputs-1:0] in_A,
  input  logic [Width_inputs-1:0] in_B,
  input  logic                    ld,
  output logic                    busy,
  output logic                    done,
  output logic [Width_inputs-1:0] quotient,
  output logic [Width_inputs-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int W = Width_inputs;
  localparam logic [Width_count-1:0] LAST = Width_count'(W - 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state;

  logic [W-1:0] q_reg;
  logic [W-1:0] d_reg;
  logic [W-1:0] a_raw;
  logic [W:0]   r_reg;
  logic         sign_q;
  logic         sign_r;
  logic         ovf_cand;
  logic         dz_pend;
  logic [Width_count-1:0] count;

  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;
  logic [W:0]   r_sh;
  logic [W+1:0] t_diff;

  // One extra bit on the trial subtraction keeps its sign unambiguous
  always_comb begin
    abs_a  = in_A[W-1] ? -in_A : in_A;
    abs_b  = in_B[W-1] ? -in_B : in_B;
    r_sh   = {r_reg[W-1:0], q_reg[W-1]};
    t_diff = {1'b0, r_sh} - {2'b00, d_reg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      a_raw       <= '0;
      r_reg       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_cand    <= 1'b0;
      dz_pend     <= 1'b0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld) begin
            q_reg       <= abs_a;
            d_reg       <= abs_b;
            a_raw       <= in_A;
            sign_q      <= in_A[W-1] ^ in_B[W-1];
            sign_r      <= in_A[W-1];
            ovf_cand    <= (in_A == MOST_NEG) && (in_B == '1);
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            dz_pend     <= (in_B == '0);
            state       <= (in_B == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          q_reg <= {q_reg[W-2:0], ~t_diff[W+1]};
          r_reg <= t_diff[W+1] ? r_sh : t_diff[W:0];
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          quotient  <= sign_q ? -q_reg : q_reg;
          remainder <= sign_r ? -r_reg[W-1:0] : r_reg[W-1:0];
          overflow  <= ovf_cand;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Divide-by-zero lands here straight from IDLE and publishes one cycle later
          if (dz_pend) begin
            quotient    <= '1;
            remainder   <= a_raw;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            dz_pend     <= 1'b0;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed vectors plus a short truncating-model sweep
// for the sequential signed divider.
module tb_seq_signed_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         ld;
  logic [W-1:0] in_A;
  logic [W-1:0] in_B;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  seq_signed_divider #(
    .Width_inputs(W),
    .Width_count (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_A       (in_A),
    .in_B       (in_B),
    .ld         (ld),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int done_cnt = 0;
  int ld_cnt   = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov,
                         input int elat, input bit poke);
    int lat;
    bit seen;
    in_A = a;
    in_B = b;
    ld   = 1'b1;
    @(posedge clk); #1;
    ld_cnt++;
    in_A = 16'hDEAD;
    in_B = 16'hBEEF;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (poke && (lat == 2 || lat == 15)) begin
        ld   = 1'b1;
        in_A = 16'h0005 + 16'(lat);
        in_B = 16'h0001;
      end else begin
        ld = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 8) check("busy_calc", busy, 1);
      if (done) seen = 1'b1;
    end
    ld = 1'b0;
    check("done_seen", seen, 1);
    check("latency", lat, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    check("overflow", overflow, eov);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc0;
    int lc0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int sa;
    int sb;

    reset = 1'b0;
    ld    = 1'b0;
    in_A  = '0;
    in_B  = '0;
    #2 reset = 1'b1;
    #10;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_flags", {div_by_zero, overflow}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_div(16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, 0);
    run_div(-16'sd100, 16'd7, 16'hFFF2, 16'hFFFE, 0, 0, 17, 0);
    run_div(16'd100, -16'sd7, 16'hFFF2, 16'h0002, 0, 0, 17, 0);
    run_div(-16'sd100, -16'sd7, 16'h000E, 16'hFFFE, 0, 0, 17, 0);
    run_div(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1, 17, 0);
    run_div(16'h8000, 16'h0001, 16'h8000, 16'h0000, 0, 0, 17, 0);
    run_div(16'd7, 16'd100, 16'h0000, 16'h0007, 0, 0, 17, 0);
    run_div(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 1, 0);
    run_div(16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, 0);
    run_div(16'h7FFF, 16'd2, 16'h3FFF, 16'h0001, 0, 0, 17, 0);
    run_div(16'hFFFF, 16'd2, 16'h0000, 16'hFFFF, 0, 0, 17, 0);
    run_div(16'd0, 16'd5, 16'h0000, 16'h0000, 0, 0, 17, 0);
    run_div(16'd1000, -16'sd33, 16'hFFE2, 16'h000A, 0, 0, 17, 0);
    run_div(16'h8000, 16'd7, 16'hEDB7, 16'hFFFF, 0, 0, 17, 0);
    run_div(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 17, 0);
    run_div(16'h8000, 16'h8000, 16'h0001, 16'h0000, 0, 0, 17, 0);

    // ld pulses during CALC must be ignored
    run_div(16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, 1);

    // reset in the middle of CALC aborts with no done pulse
    in_A = 16'd100;
    in_B = 16'd7;
    ld   = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    dc0 = done_cnt;
    #1;
    check("abort_busy", busy, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_flags", {done, div_by_zero, overflow}, 0);
    @(negedge clk) reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 0);
    run_div(16'd100, 16'd7, 16'h000E, 16'h0002, 0, 0, 17, 0);

    // back-to-back sweep against a C-style truncating model
    dc0 = done_cnt;
    lc0 = ld_cnt;
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 3 == 0) rb = {{12{rb[3]}}, rb[3:0]};
      if (i % 17 == 0) ra = 16'h8000;
      if (rb == '0) begin
        run_div(ra, rb, 16'hFFFF, ra, 1, 0, 1, 0);
      end else begin
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        run_div(ra, rb, W'(sa / sb), W'(sa % sb), 0,
                (ra == 16'h8000) && (rb == 16'hFFFF), 17, 0);
      end
    end
    check("done_vs_ld", done_cnt - dc0, ld_cnt - lc0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
